// File: rtl/gbf_fill_pkg.sv
// Shared definitions for the GBF refill controller.
//   fill_state_t               : controller FSM states (idle, filling buffer 1, filling buffer 2)
//   DEFAULT_TILE_CNT_BITWIDTH  : default width of the per-layer tile counter
package gbf_fill_pkg;

  localparam int DEFAULT_TILE_CNT_BITWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2
  } fill_state_t;

endpackage

// File: rtl/gbf_line_writer.sv
// Port-A write sequencer for one GBF buffer.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : restart the line counter at 0 (asserted when a fill begins)
//   accept       : a stream line is being accepted for this buffer this cycle
//   fill_lines   : number of lines in the current fill (1..depth)
//   in_data      : stream line to be written
//   en, we       : port-A enable / write enable, one cycle after each accept
//   addr, w_data : registered port-A address and data (hold between writes)
//   last_beat    : the line accepted this cycle is the final line of the fill
module gbf_line_writer #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [ADDR_W:0]   fill_lines,
  input  logic [DATA_W-1:0] in_data,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] w_data,
  output logic              last_beat
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  // One bit wider than the address so a full-depth fill counts to depth without wrapping.
  logic [ADDR_W:0] line_cnt;

  assign last_beat = accept && (line_cnt == fill_lines - ONE);
  assign we        = en;

  // Each accepted line becomes a port-A write in the following cycle; address and
  // data are only updated on accepts so they hold their last value in between.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt <= '0;
      en       <= 1'b0;
      addr     <= '0;
      w_data   <= '0;
    end else begin
      en <= accept;
      if (clear) begin
        line_cnt <= '0;
      end else if (accept) begin
        addr     <= line_cnt[ADDR_W-1:0];
        w_data   <= in_data;
        line_cnt <= line_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/gbf_fill_ctrl.sv
// Refill engine for one double-buffered GBF (actv or wgt).
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle pulse, latches cfg_* and begins a layer
//   finish              : aborts / ends the layer
//   cfg_fill_lines      : lines per fill, 1..GBF_DEPTH, 0 means GBF_DEPTH
//   cfg_num_tiles       : number of buffer fills in the layer
//   need_data1/2        : level requests from the gbf_controller (rising edge = request)
//   in_valid/in_data    : line stream from the off-chip loader
//   in_ready            : high while a fill is in progress
//   en/we/addr/w_data1a : buffer-1 port-A write interface
//   en/we/addr/w_data2a : buffer-2 port-A write interface
//   buf1/2_ready        : buffer holds a completed fill
//   data_avail          : fills remain in the current layer
module gbf_fill_ctrl
  import gbf_fill_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32,
  parameter int TILE_CNT_BITWIDTH = DEFAULT_TILE_CNT_BITWIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         finish,
  input  logic [GBF_ADDR_BITWIDTH:0]   cfg_fill_lines,
  input  logic [TILE_CNT_BITWIDTH-1:0] cfg_num_tiles,
  input  logic                         need_data1,
  input  logic                         need_data2,
  input  logic                         in_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         en1a,
  output logic                         we1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
  output logic                         en2a,
  output logic                         we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
  output logic                         buf1_ready,
  output logic                         buf2_ready,
  output logic                         data_avail
);

  localparam logic [GBF_ADDR_BITWIDTH:0] FULL_LINES = (GBF_ADDR_BITWIDTH + 1)'(GBF_DEPTH);
  localparam logic [TILE_CNT_BITWIDTH-1:0] ONE_TILE = TILE_CNT_BITWIDTH'(1);

  fill_state_t                  state_q, state_d;
  logic [GBF_ADDR_BITWIDTH:0]   fill_lines_q;
  logic [TILE_CNT_BITWIDTH-1:0] tiles_left, tiles_next;
  logic need1_q, need2_q, pend1, pend2;
  logic last_was2, done_q, done_buf2;
  logic go1, go2, drop, abort, tiles_avail;
  logic accept1, accept2, last1, last2;

  // start behaves like finish for an in-flight fill, then loads the new layer.
  assign abort    = start | finish;
  assign in_ready = (state_q == FILL1) || (state_q == FILL2);
  assign accept1  = (state_q == FILL1) && in_valid && !abort;
  assign accept2  = (state_q == FILL2) && in_valid && !abort;

  // A just-finished fill still counts in tiles_left for one cycle (done_q), so it
  // must be discounted when deciding whether another fill may start.
  assign tiles_avail = (tiles_left != '0) && !(done_q && (tiles_left == ONE_TILE));

  // Next state: pick a pending buffer when tiles remain (the one not filled last
  // wins a tie), drop requests when the layer is exhausted, leave FILLn on its last line.
  always_comb begin
    state_d = state_q;
    go1     = 1'b0;
    go2     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend1 || pend2) begin
          if (!tiles_avail) begin
            drop = 1'b1;
          end else if (pend1 && (!pend2 || last_was2)) begin
            go1     = 1'b1;
            state_d = FILL1;
          end else begin
            go2     = 1'b1;
            state_d = FILL2;
          end
        end
      end
      FILL1:   if (last1) state_d = IDLE;
      FILL2:   if (last2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      go1     = 1'b0;
      go2     = 1'b0;
      drop    = 1'b0;
    end
  end

  // Tile count: loaded by start, zeroed by finish, decremented one cycle after the
  // final write of a fill so data_avail falls together with bufN_ready rising.
  always_comb begin
    tiles_next = tiles_left;
    if (start) begin
      tiles_next = cfg_num_tiles;
    end else if (finish) begin
      tiles_next = '0;
    end else if (done_q && (tiles_left != '0)) begin
      tiles_next = tiles_left - ONE_TILE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      need1_q      <= 1'b0;
      need2_q      <= 1'b0;
      pend1        <= 1'b0;
      pend2        <= 1'b0;
      fill_lines_q <= '0;
      tiles_left   <= '0;
      data_avail   <= 1'b0;
      buf1_ready   <= 1'b0;
      buf2_ready   <= 1'b0;
      last_was2    <= 1'b1;
      done_q       <= 1'b0;
      done_buf2    <= 1'b0;
    end else begin
      state_q    <= state_d;
      need1_q    <= need_data1;
      need2_q    <= need_data2;
      tiles_left <= tiles_next;
      data_avail <= (tiles_next != '0);
      // A new rising edge always wins over clearing, so a request during its own fill is kept.
      if (abort) begin
        pend1 <= 1'b0;
        pend2 <= 1'b0;
      end else begin
        pend1 <= (need_data1 & ~need1_q) | (pend1 & ~go1 & ~drop);
        pend2 <= (need_data2 & ~need2_q) | (pend2 & ~go2 & ~drop);
      end
      if (start) begin
        fill_lines_q <= (cfg_fill_lines == '0) ? FULL_LINES : cfg_fill_lines;
        buf1_ready   <= 1'b0;
        buf2_ready   <= 1'b0;
        last_was2    <= 1'b1;
        done_q       <= 1'b0;
        done_buf2    <= 1'b0;
      end else begin
        done_q    <= last1 | last2;
        done_buf2 <= last2;
        if (go1) last_was2 <= 1'b0;
        else if (go2) last_was2 <= 1'b1;
        if (go1) buf1_ready <= 1'b0;
        else if (done_q && !done_buf2) buf1_ready <= 1'b1;
        if (go2) buf2_ready <= 1'b0;
        else if (done_q && done_buf2) buf2_ready <= 1'b1;
      end
    end
  end

  gbf_line_writer #(
    .DATA_W (GBF_DATA_BITWIDTH),
    .ADDR_W (GBF_ADDR_BITWIDTH)
  ) u_writer1 (
    .clk        (clk),
    .reset      (reset),
    .clear      (go1),
    .accept     (accept1),
    .fill_lines (fill_lines_q),
    .in_data    (in_data),
    .en         (en1a),
    .we         (we1a),
    .addr       (addr1a),
    .w_data     (w_data1a),
    .last_beat  (last1)
  );

  gbf_line_writer #(
    .DATA_W (GBF_DATA_BITWIDTH),
    .ADDR_W (GBF_ADDR_BITWIDTH)
  ) u_writer2 (
    .clk        (clk),
    .reset      (reset),
    .clear      (go2),
    .accept     (accept2),
    .fill_lines (fill_lines_q),
    .in_data    (in_data),
    .en         (en2a),
    .we         (we2a),
    .addr       (addr2a),
    .w_data     (w_data2a),
    .last_beat  (last2)
  );

endmodule

// File: tb/tb_gbf_fill_ctrl.sv
// Testbench for gbf_fill_ctrl: directed layer scenarios plus randomized fills.
// Accepted stream lines are pushed as expected port-A writes; a monitor pops them
// whenever a write strobe appears. Buffer-ready / tile bookkeeping is kept in a
// small model of the layer (tiles remaining, ready flag per buffer, last filled).
module tb_gbf_fill_ctrl;

  localparam int DW    = 512;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int TW    = 16;

  logic          clk = 1'b0;
  logic          reset, start, finish;
  logic [AW:0]   cfg_fill_lines;
  logic [TW-1:0] cfg_num_tiles;
  logic          need_data1, need_data2, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          en1a, we1a, en2a, we2a;
  logic [AW-1:0] addr1a, addr2a;
  logic [DW-1:0] w_data1a, w_data2a;
  logic          buf1_ready, buf2_ready, data_avail;

  typedef struct {
    int            bufn;
    int            addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  model_tiles;
  bit  model_ready [3];
  int  model_last;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  gbf_fill_ctrl #(
    .GBF_DATA_BITWIDTH (DW),
    .GBF_ADDR_BITWIDTH (AW),
    .GBF_DEPTH         (DEPTH),
    .TILE_CNT_BITWIDTH (TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .finish         (finish),
    .cfg_fill_lines (cfg_fill_lines),
    .cfg_num_tiles  (cfg_num_tiles),
    .need_data1     (need_data1),
    .need_data2     (need_data2),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .en1a           (en1a),
    .we1a           (we1a),
    .addr1a         (addr1a),
    .w_data1a       (w_data1a),
    .en2a           (en2a),
    .we2a           (we2a),
    .addr2a         (addr2a),
    .w_data2a       (w_data2a),
    .buf1_ready     (buf1_ready),
    .buf2_ready     (buf2_ready),
    .data_avail     (data_avail)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Monitor: every port-A strobe must match the oldest accepted line, one cycle later.
  always @(negedge clk) begin
    wr_t e;
    int  sel;
    if (en1a || we1a || en2a || we2a) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got en1a=%0b en2a=%0b addr1a=%0d addr2a=%0d, expected no write",
                 en1a, en2a, addr1a, addr2a);
      end else begin
        e   = exp_q.pop_front();
        sel = (en2a || we2a) ? 2 : 1;
        checkOutput("write_buffer", sel, e.bufn);
        checkOutput("write_en_we", (sel == 2) ? {en2a, we2a} : {en1a, we1a}, 2'b11);
        checkOutput("write_other_port_idle", (sel == 2) ? (en1a | we1a) : (en2a | we2a), 0);
        checkOutput("write_addr", (sel == 2) ? addr2a : addr1a, e.addr);
        checkOutput("write_data", (sel == 2) ? w_data2a : w_data1a, e.data);
        checkOutput("write_latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #(2000000);
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doStart(input int lines, input int tiles);
    @(negedge clk);
    start          = 1'b1;
    cfg_fill_lines = (AW + 1)'(lines);
    cfg_num_tiles  = TW'(tiles);
    @(negedge clk);
    start          = 1'b0;
    model_tiles    = tiles;
    model_ready[1] = 1'b0;
    model_ready[2] = 1'b0;
    model_last     = 2;
    checkOutput("start_data_avail", data_avail, tiles != 0);
    checkOutput("start_buf1_ready", buf1_ready, 0);
    checkOutput("start_buf2_ready", buf2_ready, 0);
  endtask

  task automatic pulseNeed(input logic [1:0] mask);
    @(negedge clk);
    need_data1 = mask[0];
    need_data2 = mask[1];
    @(negedge clk);
    need_data1 = 1'b0;
    need_data2 = 1'b0;
  endtask

  // Streams nlines lines; each line seen accepted becomes an expected write.
  task automatic applyStimulus(input int bufn, input int nlines, input bit gappy,
                               input int seq_base, output int waits);
    int  sent;
    wr_t e;
    sent  = 0;
    waits = 0;
    while (sent < nlines) begin
      @(negedge clk);
      if (gappy && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = (seq_base >= 0) ? DW'(seq_base + sent) : rand_line();
      end
      if (in_valid && in_ready) begin
        e.bufn = bufn;
        e.addr = sent;
        e.data = in_data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        sent++;
      end else begin
        waits++;
        if (waits > 300) begin
          tests++;
          fails++;
          $display("[TB] FAIL fill_timeout: got %0d of %0d lines accepted for buffer %0d", sent, nlines, bufn);
          break;
        end
      end
    end
  endtask

  // Called right after the last line was driven: checks the completion timing.
  task automatic finishFill(input int bufn, input int nextb);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("done_in_ready_low", in_ready, 0);
    checkOutput("done_ready_not_early", (bufn == 2) ? buf2_ready : buf1_ready, 0);
    checkOutput("done_data_avail_hold", data_avail, model_tiles != 0);
    @(negedge clk);
    model_tiles--;
    model_ready[bufn] = 1'b1;
    model_last        = bufn;
    if (nextb != 0) model_ready[nextb] = 1'b0;
    checkOutput("done_buf1_ready", buf1_ready, model_ready[1]);
    checkOutput("done_buf2_ready", buf2_ready, model_ready[2]);
    checkOutput("done_data_avail", data_avail, model_tiles != 0);
    checkOutput("done_next_fill", in_ready, nextb != 0);
  endtask

  task automatic checkIdle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rand_line();
      checkOutput("idle_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Aborts a fill that is two lines in, via finish or reset.
  task automatic abortFill(input bit use_reset);
    @(negedge clk);
    in_valid = 1'b0;
    if (use_reset) reset = 1'b1;
    else finish = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    finish      = 1'b0;
    model_tiles = 0;
    if (use_reset) begin
      model_ready[1] = 1'b0;
      model_ready[2] = 1'b0;
      model_last     = 2;
    end
    checkOutput("abort_in_ready", in_ready, 0);
    checkOutput("abort_en1a", en1a, 0);
    checkOutput("abort_buf1_ready", buf1_ready, model_ready[1]);
    checkOutput("abort_data_avail", data_avail, 0);
    checkIdle(5);
  endtask

  initial begin
    int w;
    reset = 1'b1; start = 1'b0; finish = 1'b0;
    cfg_fill_lines = '0; cfg_num_tiles = '0;
    need_data1 = 1'b0; need_data2 = 1'b0; in_valid = 1'b0; in_data = '0;
    model_tiles = 0; model_ready[1] = 1'b0; model_ready[2] = 1'b0; model_last = 2;
    repeat (3) @(negedge clk);
    checkOutput("reset_en1a", en1a, 0);
    checkOutput("reset_we1a", we1a, 0);
    checkOutput("reset_addr1a", addr1a, 0);
    checkOutput("reset_w_data1a", w_data1a, 0);
    checkOutput("reset_en2a", en2a, 0);
    checkOutput("reset_we2a", we2a, 0);
    checkOutput("reset_addr2a", addr2a, 0);
    checkOutput("reset_w_data2a", w_data2a, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_buf1_ready", buf1_ready, 0);
    checkOutput("reset_buf2_ready", buf2_ready, 0);
    checkOutput("reset_data_avail", data_avail, 0);
    reset = 1'b0;

    // Two-tile layer: buffer 1 with 0xA0..0xA3, buffer 2 with gaps, then an extra request.
    doStart(4, 2);
    pulseNeed(2'b01);
    applyStimulus(1, 4, 1'b0, 'hA0, w);
    finishFill(1, 0);
    pulseNeed(2'b10);
    applyStimulus(2, 4, 1'b1, -1, w);
    finishFill(2, 0);
    pulseNeed(2'b01);
    checkIdle(8);

    // Simultaneous requests: buffer 1 first, buffer 2 after a single idle cycle.
    doStart(3, 2);
    pulseNeed(2'b11);
    applyStimulus(1, 3, 1'b0, -1, w);
    applyStimulus(2, 3, 1'b0, -1, w);
    checkOutput("back_to_back_gap_cycles", w, 1);
    model_tiles--;
    model_ready[1] = 1'b1;
    model_last     = 1;
    finishFill(2, 0);

    // Full-depth fill selected by cfg_fill_lines = 0.
    doStart(0, 1);
    pulseNeed(2'b01);
    applyStimulus(1, DEPTH, 1'b1, -1, w);
    finishFill(1, 0);

    // Abort by finish, recover; abort by reset, recover.
    for (int k = 0; k < 2; k++) begin
      doStart(4, 3);
      pulseNeed(2'b01);
      applyStimulus(1, 2, 1'b0, -1, w);
      abortFill(k == 1);
      doStart(4, 1);
      pulseNeed(2'b01);
      applyStimulus(1, 4, 1'b1, -1, w);
      finishFill(1, 0);
    end

    // A level-held request gives exactly one fill; a fresh edge gives another.
    doStart(4, 3);
    @(negedge clk);
    need_data1 = 1'b1;
    applyStimulus(1, 4, 1'b1, -1, w);
    finishFill(1, 0);
    checkIdle(10);
    need_data1 = 1'b0;
    pulseNeed(2'b01);
    applyStimulus(1, 4, 1'b0, -1, w);
    finishFill(1, 0);

    // Randomized layers driven from the layer model.
    for (int r = 0; r < 6; r++) begin
      int         lines, tiles, nlines, nb;
      logic [1:0] mask;
      int         order[$];
      lines  = $urandom_range(0, 6);
      tiles  = $urandom_range(1, 4);
      nlines = (lines == 0) ? DEPTH : lines;
      doStart(lines, tiles);
      while (model_tiles > 0) begin
        mask = 2'($urandom_range(1, 3));
        order.delete();
        if (mask == 2'b11) begin
          if (model_last == 2) order = {1, 2};
          else order = {2, 1};
        end else begin
          order.push_back((mask == 2'b01) ? 1 : 2);
        end
        pulseNeed(mask);
        for (int k = 0; k < order.size(); k++) begin
          if (model_tiles == 0) break;
          applyStimulus(order[k], nlines, 1'($urandom_range(0, 1)), -1, w);
          nb = ((k + 1 < order.size()) && (model_tiles > 1)) ? order[k+1] : 0;
          finishFill(order[k], nb);
        end
      end
      checkIdle(3);
    end

    repeat (3) @(negedge clk);
    checkOutput("expected_writes_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
